// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for counter_updown_10bit: load the floor, count up to
// the ceiling, back down to the floor, repeated for a programmed number of round trips.
module counter_sweep_ctrl #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] low_limit,
  input  logic [WIDTH-1:0] high_limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic [PRE_W-1:0] sweeps,
  input  logic [WIDTH-1:0] q_in,
  input  logic             overflow_in,
  output logic             cnt_ce,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic             cnt_updown,
  output logic [WIDTH-1:0] cnt_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [PRE_W-1:0] sweep_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] low_q;
  logic [WIDTH-1:0] high_q;
  logic [PRE_W-1:0] pscl_q;
  logic [PRE_W-1:0] sweeps_q;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] sc_q;
  logic             err_q;

  logic             tick;
  logic             at_high;
  logic             at_low;
  logic [PRE_W-1:0] sc_d;
  logic             last_tick;
  logic             count_req;
  logic             wrap;
  logic             cfg_ok;
  logic [PRE_W-1:0] pre_d;

  always_comb begin
    tick      = ((state_q == S_UP) || (state_q == S_DOWN)) && (pre_q == pscl_q);
    at_high   = (q_in == high_q);
    at_low    = (q_in == low_q);
    sc_d      = sc_q + 1'b1;
    last_tick = (state_q == S_DOWN) && tick && at_low && (sc_d == sweeps_q);
    count_req = tick && !last_tick;
    wrap      = count_req && overflow_in;
    cfg_ok    = (low_limit < high_limit) && (sweeps != '0);
    pre_d     = tick ? '0 : pre_q + 1'b1;
  end

  // Direction depends only on state, tick and q_in so the counter's overflow
  // never feeds back into its own up/down select.
  always_comb begin
    cnt_updown = 1'b0;
    if (!abort) begin
      unique case (state_q)
        S_UP:    cnt_updown = tick && at_high;
        S_DOWN:  cnt_updown = !(tick && at_low);
        default: cnt_updown = 1'b0;
      endcase
    end
  end

  always_comb begin
    cnt_load  = (state_q == S_LOAD) && !abort;
    cnt_en    = count_req && !overflow_in && !abort;
    cnt_ce    = cnt_load || cnt_en;
    cnt_value = low_q;
    busy      = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);
    done      = (state_q == S_DONE);
    err       = err_q;
    sweep_count = sc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      low_q    <= '0;
      high_q   <= '0;
      pscl_q   <= '0;
      sweeps_q <= '0;
      pre_q    <= '0;
      sc_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                low_q    <= low_limit;
                high_q   <= high_limit;
                pscl_q   <= prescale;
                sweeps_q <= sweeps;
                sc_q     <= '0;
                state_q  <= S_LOAD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            pre_q   <= '0;
            state_q <= S_UP;
          end
          S_UP: begin
            pre_q <= pre_d;
            if (wrap) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (tick && at_high) begin
              state_q <= S_DOWN;
            end
          end
          S_DOWN: begin
            pre_q <= pre_d;
            if (wrap) begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end else if (tick && at_low) begin
              sc_q    <= sc_d;
              state_q <= last_tick ? S_DONE : S_UP;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule
